// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, OVERSAMPLE-tick bit timing, clamped word size 5..9, 1/2 stop bits.
// Optional even-parity checking is compiled in with `define UART_RX_PARITY_CHECK_EN.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_config,
    input  logic       i_uart_sample_enable,
    input  logic       i_rx,
    output logic [8:0] o_rx_parallel,
    output logic       o_rx_valid,
    output logic       o_parity_error,
    output logic       o_frame_error,
    output logic       o_busy
);
    localparam logic [4:0] LP_BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] LP_HALF_LAST = 5'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t     r_state, w_next;
    logic [1:0] r_sync;
    logic [4:0] r_cnt;
    logic [3:0] r_idx;
    logic [8:0] r_data;
    logic       r_ferr;
    logic       r_stop_idx;
    logic [3:0] r_cfg_wsize;
    logic       r_cfg_stop2;
    logic [3:0] w_cfg_wsize;
    logic       w_rx_s, w_par_en, w_bit_done, w_half_done, w_last_data, w_last_stop;

    assign w_rx_s      = r_sync[1];
    assign o_busy      = (r_state != S_IDLE);
    assign w_bit_done  = i_uart_sample_enable && (r_cnt == LP_BIT_LAST);
    assign w_half_done = i_uart_sample_enable && (r_cnt == LP_HALF_LAST);
    assign w_last_data = (r_idx == r_cfg_wsize - 4'd1);
    assign w_last_stop = (r_state == S_STOP) && w_bit_done && (r_stop_idx == r_cfg_stop2);

    always_comb begin
        w_cfg_wsize = i_config[4:1];
        if (i_config[4:1] < 4'd5)      w_cfg_wsize = 4'd5;
        else if (i_config[4:1] > 4'd9) w_cfg_wsize = 4'd9;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b11;
            r_state <= S_IDLE;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (!w_rx_s) w_next = S_START;
            S_START:     if (w_half_done) w_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (w_bit_done && w_last_data) w_next = w_par_en ? S_PARITY : S_STOP;
            S_PARITY:    if (w_bit_done) w_next = S_STOP;
            S_STOP:      if (w_last_stop) w_next = w_rx_s ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_rx_s) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Counter restarts on every state change and after each full bit period.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (i_uart_sample_enable && r_state != S_IDLE && r_state != S_WAIT_IDLE) begin
            r_cnt <= w_bit_done ? 5'd0 : r_cnt + 5'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cfg_wsize   <= 4'd8;
            r_cfg_stop2   <= 1'b0;
            r_idx         <= '0;
            r_data        <= '0;
            r_ferr        <= 1'b0;
            r_stop_idx    <= 1'b0;
            o_rx_parallel <= '0;
            o_rx_valid    <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            if (r_state == S_IDLE && i_config[0]) begin
                r_cfg_wsize <= w_cfg_wsize;
                r_cfg_stop2 <= i_config[6];
            end
            if (r_state == S_START && w_half_done && !w_rx_s) begin
                r_idx      <= '0;
                r_data     <= '0;
                r_ferr     <= 1'b0;
                r_stop_idx <= 1'b0;
            end
            if (r_state == S_DATA && w_bit_done) begin
                r_data[r_idx] <= w_rx_s;
                r_idx         <= r_idx + 4'd1;
            end
            if (r_state == S_STOP && w_bit_done) begin
                r_stop_idx <= 1'b1;
                if (!w_rx_s) r_ferr <= 1'b1;
            end
            if (w_last_stop) begin
                o_rx_parallel <= r_data;
                o_frame_error <= r_ferr | ~w_rx_s;
                o_rx_valid    <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_CHECK_EN
    logic r_cfg_par, r_perr;
    assign w_par_en = r_cfg_par;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cfg_par      <= 1'b0;
            r_perr         <= 1'b0;
            o_parity_error <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_config[0]) r_cfg_par <= i_config[5];
            if (r_state == S_START && w_half_done && !w_rx_s) r_perr <= 1'b0;
            // Even parity over the zero-padded word.
            if (r_state == S_PARITY && w_bit_done) r_perr <= w_rx_s ^ (^r_data);
            if (w_last_stop) o_parity_error <= r_perr;
        end
    end
`else
    logic w_unused_cfg_par;
    assign w_unused_cfg_par = i_config[5];
    assign w_par_en         = 1'b0;
    assign o_parity_error   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit-by-bit, expected words queued, strobes checked by a monitor.
module tb_uart_rx;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = 16 * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] cfg;
    logic       tick;
    logic       rx;
    logic [8:0] rx_par;
    logic       rx_vld, perr, ferr, busy;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_config(cfg), .i_uart_sample_enable(tick),
        .i_rx(rx), .o_rx_parallel(rx_par), .o_rx_valid(rx_vld),
        .o_parity_error(perr), .o_frame_error(ferr), .o_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk) tick = 1'b0;
            @(negedge clk) tick = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rx_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 9'd1, 9'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_data", rx_par, e.data);
                chk("rx_perr", {8'd0, perr}, {8'd0, e.perr});
                chk("rx_ferr", {8'd0, ferr}, {8'd0, e.ferr});
            end
        end
    end

    task automatic wait_bit();
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic cfg_pulse(input logic [6:0] v);
        cfg = {v[6:1], 1'b1};
        @(negedge clk);
        cfg[0] = 1'b0;
    endtask

    task automatic expect_word(input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d; e.perr = p; e.ferr = f;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [8:0] d, input int nbits, input bit has_par, input logic par_bit,
                        input bit two_stop, input logic stop2);
        rx = 1'b0; wait_bit();
        for (int i = 0; i < nbits; i++) begin
            rx = d[i]; wait_bit();
        end
        if (has_par) begin
            rx = par_bit; wait_bit();
        end
        rx = 1'b1; wait_bit();
        if (two_stop) begin
            rx = stop2; wait_bit();
        end
    endtask

    initial begin
        rst = 1'b1; cfg = 7'd0; rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_data", rx_par, 9'd0);
        chk("reset_valid", {8'd0, rx_vld}, 9'd0);
        chk("reset_busy", {8'd0, busy}, 9'd0);
        chk("reset_ferr", {8'd0, ferr}, 9'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Defaults: 8 data bits, 1 stop
        expect_word(9'h0A5, 1'b0, 1'b0);
        send(9'h0A5, 8, 0, 1'b0, 0, 1'b1);
        wait_bit();

        // Config strobe while busy must not change the 8-bit framing
        expect_word(9'h05A, 1'b0, 1'b0);
        fork
            send(9'h05A, 8, 0, 1'b0, 0, 1'b1);
            begin
                repeat (3 * BIT_CLK) @(negedge clk);
                cfg_pulse(7'b0_0_1100_0);
            end
        join
        wait_bit();

        // Same strobe in IDLE clamps word size 12 to 9
        cfg_pulse(7'b0_0_1100_0);
        expect_word(9'h1A5, 1'b0, 1'b0);
        send(9'h1A5, 9, 0, 1'b0, 0, 1'b1);
        wait_bit();

        // Word 9, two stop bits, second stop low, line then stuck low
        cfg_pulse(7'b1_0_1001_0);
        expect_word(9'h1FF, 1'b0, 1'b1);
        send(9'h1FF, 9, 0, 1'b0, 1, 1'b0);
        wait_bit(); wait_bit();
        chk("wait_idle_busy", {8'd0, busy}, 9'd1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        chk("wait_idle_release", {8'd0, busy}, 9'd0);
        wait_bit();

        // Word 5 with parity requested
        cfg_pulse(7'b0_1_0101_0);
`ifdef UART_RX_PARITY_CHECK_EN
        expect_word(9'h013, 1'b0, 1'b0);
        send(9'h013, 5, 1, 1'b1, 0, 1'b1);
        wait_bit();
        expect_word(9'h013, 1'b1, 1'b0);
        send(9'h013, 5, 1, 1'b0, 0, 1'b1);
`else
        // No parity state: the extra line bit is taken as the stop bit
        expect_word(9'h013, 1'b0, 1'b0);
        send(9'h013, 5, 1, 1'b1, 0, 1'b1);
        wait_bit();
        expect_word(9'h013, 1'b0, 1'b1);
        send(9'h013, 5, 1, 1'b0, 0, 1'b1);
`endif
        wait_bit();

        // Three-tick low glitch on idle line
        rx = 1'b0;
        repeat (6) @(negedge clk);
        chk("glitch_busy", {8'd0, busy}, 9'd1);
        repeat (3 * TICK_DIV - 6) @(negedge clk);
        rx = 1'b1;
        repeat (48 - 3 * TICK_DIV) @(negedge clk);
        chk("glitch_idle", {8'd0, busy}, 9'd0);
        wait_bit();

        // Reset during DATA, then a clean frame with default config
        rx = 1'b0; wait_bit();
        rx = 1'b1; wait_bit(); wait_bit();
        rx = 1'b0; repeat (BIT_CLK / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_busy", {8'd0, busy}, 9'd0);
        chk("rst_mid_data", rx_par, 9'd0);
        wait_bit();
        expect_word(9'h03C, 1'b0, 1'b0);
        send(9'h03C, 8, 0, 1'b0, 0, 1'b1);
        wait_bit();

        chk("pending_expected", 9'(exp_q.size()), 9'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
